// File: rtl/canny_pkg.sv
// Shared constants for the edge-detection pipeline: pixel/magnitude widths,
// 3x3 window tap indices (row-major, top-left first) and the 8-bit clamp value.
package canny_pkg;

  localparam int PIXEL_W   = 8;
  localparam int MAG_W     = 11;
  localparam int N_TAPS    = 9;
  localparam int CLAMP_MAX = 255;

  localparam int P_TL = 0;
  localparam int P_TC = 1;
  localparam int P_TR = 2;
  localparam int P_ML = 3;
  localparam int P_MC = 4;
  localparam int P_MR = 5;
  localparam int P_BL = 6;
  localparam int P_BC = 7;
  localparam int P_BR = 8;

endpackage

// File: rtl/sobel_kernel.sv
// One-axis Sobel weighted difference: (a + 2b + c) - (d + 2e + f).
// Each weighted sum fits PIXEL_W+2 unsigned bits, so the signed result needs PIXEL_W+3.
module sobel_kernel #(
  parameter int PIXEL_W = canny_pkg::PIXEL_W,
  parameter int GRAD_W  = PIXEL_W + 3
) (
  input  logic [PIXEL_W-1:0]       i_a,
  input  logic [PIXEL_W-1:0]       i_b,
  input  logic [PIXEL_W-1:0]       i_c,
  input  logic [PIXEL_W-1:0]       i_d,
  input  logic [PIXEL_W-1:0]       i_e,
  input  logic [PIXEL_W-1:0]       i_f,
  output logic signed [GRAD_W-1:0] o_diff
);

  localparam int SUM_W = PIXEL_W + 2;

  logic [SUM_W-1:0] w_pos;
  logic [SUM_W-1:0] w_neg;

  assign w_pos = SUM_W'(i_a) + (SUM_W'(i_b) << 1) + SUM_W'(i_c);
  assign w_neg = SUM_W'(i_d) + (SUM_W'(i_e) << 1) + SUM_W'(i_f);

  // Zero-extend both sums before the subtract so the sign bit is never lost.
  assign o_diff = $signed(GRAD_W'(w_pos)) - $signed(GRAD_W'(w_neg));

endmodule

// File: rtl/gradient_calculation.sv
// Two-stage Sobel gradient pipeline: stage 1 holds Gx/Gy and clamped x/y pixels,
// stage 2 holds |Gx|+|Gy| and its clamped edge-intensity pixel.
module gradient_calculation #(
  parameter int PIXEL_W = canny_pkg::PIXEL_W,
  parameter int MAG_W   = canny_pkg::MAG_W
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [9*PIXEL_W-1:0]   gradient_data_in,
  input  logic                   gradient_data_in_valid,
  output logic [PIXEL_W-1:0]     pixel_out_x,
  output logic [PIXEL_W-1:0]     pixel_out_y,
  output logic                   pixel_xy_valid,
  output logic [MAG_W-1:0]       gradient_magnitude,
  output logic [PIXEL_W-1:0]     pixel_out,
  output logic                   gradient_out_valid
);

  import canny_pkg::*;

  localparam int GRAD_W = PIXEL_W + 3;

  function automatic logic [GRAD_W-1:0] f_abs(input logic signed [GRAD_W-1:0] v);
    return v[GRAD_W-1] ? GRAD_W'(-v) : GRAD_W'(v);
  endfunction

  function automatic logic [PIXEL_W-1:0] f_clamp_g(input logic [GRAD_W-1:0] v);
    return (v > GRAD_W'(CLAMP_MAX)) ? PIXEL_W'(CLAMP_MAX) : v[PIXEL_W-1:0];
  endfunction

  function automatic logic [PIXEL_W-1:0] f_clamp_m(input logic [MAG_W-1:0] v);
    return (v > MAG_W'(CLAMP_MAX)) ? PIXEL_W'(CLAMP_MAX) : v[PIXEL_W-1:0];
  endfunction

  logic [PIXEL_W-1:0]       w_p [N_TAPS];
  logic signed [GRAD_W-1:0] w_gx;
  logic signed [GRAD_W-1:0] w_gy;
  logic [GRAD_W-1:0]        w_abs_rx;
  logic [GRAD_W-1:0]        w_abs_ry;
  logic [MAG_W-1:0]         w_mag;

  logic signed [GRAD_W-1:0] r_gx;
  logic signed [GRAD_W-1:0] r_gy;
  logic [PIXEL_W-1:0]       r_px_x;
  logic [PIXEL_W-1:0]       r_px_y;
  logic                     r_xy_valid;
  logic [MAG_W-1:0]         r_mag;
  logic [PIXEL_W-1:0]       r_pix;
  logic                     r_grad_valid;

  for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
    assign w_p[gi] = gradient_data_in[gi*PIXEL_W +: PIXEL_W];
  end

  sobel_kernel #(.PIXEL_W(PIXEL_W), .GRAD_W(GRAD_W)) u_sobel_x (
    .i_a    (w_p[P_TR]),
    .i_b    (w_p[P_MR]),
    .i_c    (w_p[P_BR]),
    .i_d    (w_p[P_TL]),
    .i_e    (w_p[P_ML]),
    .i_f    (w_p[P_BL]),
    .o_diff (w_gx)
  );

  sobel_kernel #(.PIXEL_W(PIXEL_W), .GRAD_W(GRAD_W)) u_sobel_y (
    .i_a    (w_p[P_BL]),
    .i_b    (w_p[P_BC]),
    .i_c    (w_p[P_BR]),
    .i_d    (w_p[P_TL]),
    .i_e    (w_p[P_TC]),
    .i_f    (w_p[P_TR]),
    .o_diff (w_gy)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_gx       <= '0;
      r_gy       <= '0;
      r_px_x     <= '0;
      r_px_y     <= '0;
      r_xy_valid <= 1'b0;
    end else begin
      r_xy_valid <= gradient_data_in_valid;
      if (gradient_data_in_valid) begin
        r_gx   <= w_gx;
        r_gy   <= w_gy;
        r_px_x <= f_clamp_g(f_abs(w_gx));
        r_px_y <= f_clamp_g(f_abs(w_gy));
      end
    end
  end

  // Magnitude is built from the registered gradients so stage 2 stays a single adder.
  assign w_abs_rx = f_abs(r_gx);
  assign w_abs_ry = f_abs(r_gy);
  assign w_mag    = MAG_W'(w_abs_rx) + MAG_W'(w_abs_ry);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_mag        <= '0;
      r_pix        <= '0;
      r_grad_valid <= 1'b0;
    end else begin
      r_grad_valid <= r_xy_valid;
      if (r_xy_valid) begin
        r_mag <= w_mag;
        r_pix <= f_clamp_m(w_mag);
      end
    end
  end

  assign pixel_out_x        = r_px_x;
  assign pixel_out_y        = r_px_y;
  assign pixel_xy_valid     = r_xy_valid;
  assign gradient_magnitude = r_mag;
  assign pixel_out          = r_pix;
  assign gradient_out_valid = r_grad_valid;

endmodule

// File: tb/tb_gradient_calculation.sv
// Bench for gradient_calculation: fixed vector table, hand-built valid/reset
// sequences, and a randomized stream checked against a 3x3 convolution model.
module tb_gradient_calculation;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [71:0] gradient_data_in = '0;
  logic        gradient_data_in_valid = 1'b0;
  logic [7:0]  pixel_out_x;
  logic [7:0]  pixel_out_y;
  logic        pixel_xy_valid;
  logic [10:0] gradient_magnitude;
  logic [7:0]  pixel_out;
  logic        gradient_out_valid;

  gradient_calculation dut (
    .clk                    (clk),
    .rstN                   (rstN),
    .gradient_data_in       (gradient_data_in),
    .gradient_data_in_valid (gradient_data_in_valid),
    .pixel_out_x            (pixel_out_x),
    .pixel_out_y            (pixel_out_y),
    .pixel_xy_valid         (pixel_xy_valid),
    .gradient_magnitude     (gradient_magnitude),
    .pixel_out              (pixel_out),
    .gradient_out_valid     (gradient_out_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int kx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int ky [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  // Reference state: what each output should show after the current edge.
  logic        m_xyv, m_gv, m_prev_v;
  logic [71:0] m_prev_w;
  int          m_x, m_y, m_mag, m_pix;

  typedef struct {
    logic [71:0] win;
    int          ex;
    int          ey;
    int          emag;
    int          epix;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clamp255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [71:0] win9(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
    logic [71:0] w;
    int p [9];
    p = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(p[i]);
    return w;
  endfunction

  task automatic ref_grad(input logic [71:0] w, output int gx, output int gy);
    gx = 0;
    gy = 0;
    for (int i = 0; i < 9; i++) begin
      gx += kx[i] * int'(w[i*8 +: 8]);
      gy += ky[i] * int'(w[i*8 +: 8]);
    end
  endtask

  function automatic logic [71:0] rand_win();
    logic [71:0] w;
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < 9; i++) begin
      case (mode)
        0:       w[i*8 +: 8] = 8'($urandom_range(0, 255));
        1:       w[i*8 +: 8] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        default: w[i*8 +: 8] = 8'($urandom_range(0, 20));
      endcase
    end
    return w;
  endfunction

  task automatic model_reset();
    m_xyv = 0; m_gv = 0; m_prev_v = 0; m_prev_w = '0;
    m_x = 0; m_y = 0; m_mag = 0; m_pix = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_xy_valid"}, int'(pixel_xy_valid), int'(m_xyv));
    check({tag, "_grad_valid"}, int'(gradient_out_valid), int'(m_gv));
    check({tag, "_x"}, int'(pixel_out_x), m_x);
    check({tag, "_y"}, int'(pixel_out_y), m_y);
    check({tag, "_mag"}, int'(gradient_magnitude), m_mag);
    check({tag, "_pix"}, int'(pixel_out), m_pix);
  endtask

  // Called at posedge+1; drives one input cycle, clocks it, checks all outputs.
  task automatic run_cycle(input string tag, input logic v, input logic [71:0] w);
    int gx, gy;
    gradient_data_in_valid = v;
    gradient_data_in       = w;
    @(posedge clk);
    #1;
    if (m_prev_v) begin
      ref_grad(m_prev_w, gx, gy);
      m_mag = iabs(gx) + iabs(gy);
      m_pix = clamp255(m_mag);
    end
    m_gv = m_prev_v;
    if (v) begin
      ref_grad(w, gx, gy);
      m_x = clamp255(iabs(gx));
      m_y = clamp255(iabs(gy));
    end
    m_xyv    = v;
    m_prev_v = v;
    m_prev_w = w;
    check_all(tag);
  endtask

  initial begin
    vecs[0] = '{win9(100,100,100,100,100,100,100,100,100),   0,   0,    0,   0};
    vecs[1] = '{win9(0,77,255, 0,77,255, 0,77,255),        255,   0, 1020, 255};
    vecs[2] = '{win9(0,0,0, 5,5,5, 10,10,10),                0,  40,   40,  40};
    vecs[3] = '{win9(0,0,255, 0,0,255, 255,255,255),       255, 255, 1530, 255};
    vecs[4] = '{win9(255,9,0, 255,9,0, 255,9,0),           255,   0, 1020, 255};
    vecs[5] = '{win9(255,255,255, 0,0,0, 0,0,0),             0, 255, 1020, 255};
    vecs[6] = '{win9(255,255,0, 255,0,0, 0,0,0),           255, 255, 1530, 255};
    vecs[7] = '{win9(0,0,0, 0,0,3, 0,0,0),                   6,   0,    6,   6};
    vecs[8] = '{win9(0,0,0, 0,0,127, 0,0,0),               254,   0,  254, 254};
    vecs[9] = '{win9(0,0,0, 0,0,128, 0,0,0),               255,   0,  256, 255};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rstN = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_cycle($sformatf("vec%0d_s1", i), 1'b1, vecs[i].win);
      check($sformatf("vec%0d_x", i), int'(pixel_out_x), vecs[i].ex);
      check($sformatf("vec%0d_y", i), int'(pixel_out_y), vecs[i].ey);
      run_cycle($sformatf("vec%0d_s2", i), 1'b0, '0);
      check($sformatf("vec%0d_mag", i), int'(gradient_magnitude), vecs[i].emag);
      check($sformatf("vec%0d_pix", i), int'(pixel_out), vecs[i].epix);
      check($sformatf("vec%0d_gvalid", i), int'(gradient_out_valid), 1);
    end

    // Valid pattern 1,0,1,1 with distinct windows, then drain.
    run_cycle("gap_a", 1'b1, vecs[1].win);
    run_cycle("gap_b", 1'b0, vecs[3].win);
    run_cycle("gap_c", 1'b1, vecs[2].win);
    check("gap_c_xyv_seq", int'(pixel_xy_valid), 1);
    check("gap_c_gv_seq", int'(gradient_out_valid), 0);
    run_cycle("gap_d", 1'b1, vecs[7].win);
    check("gap_d_mag_order", int'(gradient_magnitude), 40);
    run_cycle("gap_e", 1'b0, '0);
    check("gap_e_mag_order", int'(gradient_magnitude), 6);
    run_cycle("gap_f", 1'b0, '0);

    // Reset pulse mid-stream: outputs clear asynchronously, nothing stale after.
    run_cycle("rst_pre_a", 1'b1, vecs[3].win);
    run_cycle("rst_pre_b", 1'b1, vecs[1].win);
    gradient_data_in_valid = 1'b1;
    gradient_data_in       = vecs[4].win;
    #2;
    rstN = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle($sformatf("rst_post%0d", i), 1'b0, '0);
    run_cycle("rst_first", 1'b1, vecs[2].win);
    run_cycle("rst_first_s2", 1'b0, '0);

    for (int i = 0; i < 400; i++)
      run_cycle("rand", ($urandom_range(0, 3) != 0), rand_win());
    run_cycle("rand_drain0", 1'b0, '0);
    run_cycle("rand_drain1", 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gradient_calculation.md
GRADIENT_CALCULATION -- requirements
Module: gradient_calculation

Interface
REQ-001 SHALL have parameter PIXEL_W, default 8: pixel and clamped-output width.
REQ-002 SHALL have parameter MAG_W, default 11: magnitude width, sized so |Gx|+|Gy| up to 2040 fits.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rstN  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port gradient_data_in  input  9*PIXEL_W (72): 3x3 window; pixel p[i] = bits [8i+7:8i], i=0..8 row-major, p0 top-left, p4 centre, p8 bottom-right; unsigned.
REQ-006 SHALL have port gradient_data_in_valid  input  1: window valid this cycle.
REQ-007 SHALL have port pixel_out_x  output  PIXEL_W: min(|Gx|,255).
REQ-008 SHALL have port pixel_out_y  output  PIXEL_W: min(|Gy|,255).
REQ-009 SHALL have port pixel_xy_valid  output  1: qualifies pixel_out_x/pixel_out_y.
REQ-010 SHALL have port gradient_magnitude  output  MAG_W: |Gx|+|Gy|, unsigned, unclamped.
REQ-011 SHALL have port pixel_out  output  PIXEL_W: min(gradient_magnitude,255), edge-intensity pixel.
REQ-012 SHALL have port gradient_out_valid  output  1: qualifies gradient_magnitude and pixel_out.

Function
REQ-013 SHALL compute Gx = (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6) (Sobel, right minus left).
REQ-014 SHALL compute Gy = (p6 + 2*p7 + p8) - (p0 + 2*p1 + p2) (Sobel, bottom minus top).
REQ-015 SHALL hold Gx, Gy as 11-bit signed (range -1020..+1020); no intermediate overflow.
REQ-016 SHALL use two register stages. Stage 1 registers Gx, Gy, the clamped x/y outputs and pixel_xy_valid. Stage 2 registers gradient_magnitude, pixel_out and gradient_out_valid from the stage-1 values.
REQ-017 SHALL assert pixel_xy_valid exactly 1 cycle after the input cycle with gradient_data_in_valid=1.
REQ-018 SHALL assert gradient_out_valid exactly 2 cycles after that input cycle.
REQ-019 SHALL accept one window per cycle with no backpressure: fully pipelined, throughput 1 window per clock.
REQ-020 SHALL propagate input valid gaps as equal-length valid gaps in both output valids, preserving order.
REQ-021 SHALL update data registers only when the corresponding stage's valid input is 1; otherwise data registers hold their values while valid deasserts.
REQ-022 SHALL make magnitude saturation (clamp to 255) apply only to pixel_out; gradient_magnitude carries the full value.
REQ-023 SHALL treat all inputs as unsigned; absolute values SHALL be exact, including -1020 -> 1020.

Reset
REQ-024 SHALL, while rstN=0, asynchronously force every output and pipeline register to 0, including both valids.
REQ-025 SHALL discard in-flight windows on reset mid-stream; the first valid after reset comes from the first window accepted after rstN rises.

Structure
REQ-026 SHALL take PIXEL_W, MAG_W, the window-index constants (P_TL..P_BR = 0..8) and the clamp constant 255 from the shared package canny_pkg.
REQ-027 SHALL put the one-axis weighted difference (a + 2b + c) - (d + 2e + f) in sub-module sobel_kernel, instantiated twice (x and y).
REQ-028 SHALL implement abs and clamp inline in gradient_calculation.

Verification
REQ-029 SHALL verify: all nine pixels = 100 -> x=0, y=0, magnitude=0, pixel_out=0.
REQ-030 SHALL verify: left column 0, middle column any value, right column 255 -> Gx=1020; x=255, y=0 at cycle +1; magnitude=1020, pixel_out=255 at cycle +2.
REQ-031 SHALL verify: top row 0, middle row 5, bottom row 10 -> Gy=40; x=0, y=40, magnitude=40, pixel_out=40.
REQ-032 SHALL verify: p2,p5,p6,p7,p8=255 and others 0 -> Gx=765, Gy=765; x=255, y=255, magnitude=1530, pixel_out=255.
REQ-033 SHALL verify: valid pattern 1,0,1,1 with distinct windows -> pixel_xy_valid shows the same pattern 1 cycle later and gradient_out_valid 2 cycles later, with data in input order.
REQ-034 SHALL verify: rstN pulsed low for 1 cycle mid-stream -> all outputs 0 immediately; no stale valid afterwards.
